// File: rtl/shift_cmd_sequencer.sv
// Command sequencer for the 8-bit barrel shifter: buffers {op,amt,data,rep}
// commands in a small FIFO and replays each one (rep+1) times on sh_c/sh_s/sh_i.
module shift_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_amt,
    input  logic [7:0] cmd_data,
    input  logic [2:0] cmd_rep,
    output logic [1:0] sh_c,
    output logic [2:0] sh_s,
    output logic [7:0] sh_i,
    output logic       done,
    output logic       busy
);
    typedef enum logic {IDLE, ISSUE} state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] amt;
        logic [7:0] data;
        logic [2:0] rep;
    } cmd_t;

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    state_t           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic [1:0]       sh_c_q, sh_c_d;
    logic [2:0]       sh_s_q, sh_s_d;
    logic [7:0]       sh_i_q, sh_i_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             push, pop, full, empty;
    cmd_t             head;

    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem_q[rd_ptr_q];

    assign sh_c = sh_c_q;
    assign sh_s = sh_s_q;
    assign sh_i = sh_i_q;
    assign done = done_q;
    assign busy = busy_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sh_c_d  = sh_c_q;
        sh_s_d  = sh_s_q;
        sh_i_d  = sh_i_q;
        done_d  = done_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (empty) begin
                    sh_c_d = 2'b00;
                    done_d = 1'b0;
                end else begin
                    pop = 1'b1;
                end
            end
            ISSUE: begin
                if (rem_q != 3'd0) begin
                    rem_d  = rem_q - 3'd1;
                    done_d = (rem_q == 3'd1);
                end else if (!empty) begin
                    pop = 1'b1;
                end else begin
                    sh_c_d  = 2'b00;
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A pop loads the head straight onto the shifter controls, so
        // consecutive commands run with no idle cycle between them.
        if (pop) begin
            sh_c_d  = head.op;
            sh_s_d  = head.amt;
            sh_i_d  = head.data;
            rem_d   = head.rep;
            done_d  = (head.rep == 3'd0);
            state_d = ISSUE;
        end
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        busy_d = (state_d == ISSUE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{op: cmd_op, amt: cmd_amt, data: cmd_data, rep: cmd_rep};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            rem_q    <= 3'd0;
            sh_c_q   <= 2'b00;
            sh_s_q   <= 3'd0;
            sh_i_q   <= 8'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            state_q <= state_d;
            rem_q   <= rem_d;
            sh_c_q  <= sh_c_d;
            sh_s_q  <= sh_s_d;
            sh_i_q  <= sh_i_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the issue stream.
module tb_shift_cmd_sequencer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_amt = 3'd0;
    logic [7:0] cmd_data = 8'd0;
    logic [2:0] cmd_rep = 3'd0;
    logic       cmd_ready;
    logic [1:0] sh_c;
    logic [2:0] sh_s;
    logic [7:0] sh_i;
    logic       done;
    logic       busy;

    always #5 clk = ~clk;

    shift_cmd_sequencer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data), .cmd_rep(cmd_rep),
        .sh_c(sh_c), .sh_s(sh_s), .sh_i(sh_i), .done(done), .busy(busy)
    );

    typedef struct {
        logic [1:0] op;
        logic [2:0] amt;
        logic [7:0] data;
        int         issues;
    } mcmd_t;

    // Model: queue of pending commands and the number of issues still owed
    // for the command on the outputs (1 = final issue showing now).
    mcmd_t      q[$];
    int         left = 0;
    logic [1:0] m_c = 2'b00;
    logic [2:0] m_s = 3'd0;
    logic [7:0] m_i = 8'd0;
    logic       m_done = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        mcmd_t h;
        bit    accept;
        if (rst) begin
            q.delete();
            left = 0;
            m_c = 2'b00; m_s = 3'd0; m_i = 8'd0; m_done = 1'b0;
        end else begin
            accept = cmd_valid && (q.size() < DEPTH);
            if (left > 1) begin
                left--;
            end else if (q.size() > 0) begin
                h = q.pop_front();
                m_c = h.op; m_s = h.amt; m_i = h.data;
                left = h.issues;
            end else begin
                m_c = 2'b00;
                left = 0;
            end
            m_done = (left == 1);
            if (accept) begin
                h.op = cmd_op; h.amt = cmd_amt; h.data = cmd_data;
                h.issues = int'(cmd_rep) + 1;
                q.push_back(h);
            end
        end
        m_busy  = (left > 0) || (q.size() > 0);
        m_ready = (q.size() < DEPTH);
    endtask

    task automatic compare_all();
        check("sh_c", sh_c, m_c);
        check("sh_s", sh_s, m_s);
        check("sh_i", sh_i, m_i);
        check("done", done, m_done);
        check("busy", busy, m_busy);
        check("cmd_ready", cmd_ready, m_ready);
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] op,
                        input logic [2:0] amt, input logic [7:0] data, input logic [2:0] rep);
        rst = r; cmd_valid = v; cmd_op = op; cmd_amt = amt; cmd_data = data; cmd_rep = rep;
        @(posedge clk);
        model_edge();
        #1 compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'b00, 3'd0, 8'd0, 3'd0);
    endtask

    initial begin
        int n_shift, n_done;

        // Reset and quiet idle
        step(1'b1, 1'b0, 2'b00, 3'd0, 8'd0, 3'd0);
        step(1'b1, 1'b0, 2'b00, 3'd0, 8'd0, 3'd0);
        check("rst_busy_lit", busy, 1'b0);
        check("rst_ready_lit", cmd_ready, 1'b1);
        idle(10);
        check("idle_c_lit", sh_c, 2'b00);

        // Single load
        step(1'b0, 1'b1, 2'b11, 3'd0, 8'hA5, 3'd0);
        idle(1);
        check("load_c_lit", sh_c, 2'b11);
        check("load_i_lit", sh_i, 8'hA5);
        check("load_done_lit", done, 1'b1);
        idle(1);
        check("load_end_c_lit", sh_c, 2'b00);
        check("load_end_busy_lit", busy, 1'b0);
        check("load_hold_i_lit", sh_i, 8'hA5);

        // Load 0x01 then shift left by 1, seven times
        step(1'b0, 1'b1, 2'b11, 3'd0, 8'h01, 3'd0);
        idle(2);
        step(1'b0, 1'b1, 2'b01, 3'd1, 8'h5C, 3'd6);
        n_shift = 0; n_done = 0;
        for (int k = 0; k < 10; k++) begin
            idle(1);
            if (sh_c === 2'b01) n_shift++;
            if (done === 1'b1) begin
                n_done++;
                check("rep_done_on_last_lit", n_shift, 7);
            end
        end
        check("rep_shift_len_lit", n_shift, 7);
        check("rep_done_count_lit", n_done, 1);

        // Long command in flight, fill FIFO, drop the overflow push
        step(1'b0, 1'b1, 2'b01, 3'd3, 8'h11, 3'd7);
        step(1'b0, 1'b1, 2'b10, 3'd2, 8'h22, 3'd0);
        step(1'b0, 1'b1, 2'b11, 3'd0, 8'h33, 3'd1);
        step(1'b0, 1'b1, 2'b01, 3'd5, 8'h44, 3'd0);
        step(1'b0, 1'b1, 2'b00, 3'd0, 8'h55, 3'd2);
        check("full_ready_lit", cmd_ready, 1'b0);
        step(1'b0, 1'b1, 2'b10, 3'd7, 8'h66, 3'd0);
        check("full_drop_ready_lit", cmd_ready, 1'b0);
        idle(20);

        // Simultaneous push/pop keeps one entry queued
        step(1'b0, 1'b1, 2'b01, 3'd1, 8'h0A, 3'd0);
        step(1'b0, 1'b1, 2'b10, 3'd2, 8'h0B, 3'd0);
        check("pp_c0_lit", sh_c, 2'b01);
        step(1'b0, 1'b1, 2'b11, 3'd3, 8'h0C, 3'd0);
        check("pp_c1_lit", sh_c, 2'b10);
        idle(1);
        check("pp_c2_lit", sh_c, 2'b11);
        idle(3);

        // Reset in the middle of a repeating command with entries queued
        step(1'b0, 1'b1, 2'b01, 3'd1, 8'h77, 3'd7);
        step(1'b0, 1'b1, 2'b10, 3'd1, 8'h88, 3'd0);
        step(1'b0, 1'b1, 2'b11, 3'd0, 8'h99, 3'd0);
        idle(1);
        step(1'b1, 1'b0, 2'b00, 3'd0, 8'd0, 3'd0);
        check("midrst_c_lit", sh_c, 2'b00);
        check("midrst_busy_lit", busy, 1'b0);
        check("midrst_done_lit", done, 1'b0);
        n_shift = 0;
        for (int k = 0; k < 10; k++) begin
            idle(1);
            if (sh_c !== 2'b00) n_shift++;
        end
        check("midrst_no_issue_lit", n_shift, 0);

        // Random traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 97) == 0, ($urandom % 3) != 0,
                 2'($urandom), 3'($urandom), 8'($urandom),
                 (($urandom % 4) == 0) ? 3'($urandom) : 3'd0);
        end
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_cmd_sequencer.md
Name: shift_cmd_sequencer

Overview:
- Upstream command stage for the 8-bit barrel shifter.
- Buffers shift commands in a small FIFO and issues them one per clock on the shifter's control inputs: c (op), s (amount) and i (load data).
- Each command carries a repeat count, so multi-step shifts and delays run without CPU intervention.
- Sits between the command source (valid/ready) and the shifter's c/s/i inputs; the shifter samples them on the same clk edge as its own registers.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- PTR_W, 2: FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock shared with the shifter.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command present on the cmd_* inputs.
- cmd_ready  output  1  FIFO can accept a command; equals !full.
- cmd_op  input  2  00 hold, 01 shift left, 10 shift right, 11 load.
- cmd_amt  input  3  shift amount, 0..7.
- cmd_data  input  8  load data; used only when op=11.
- cmd_rep  input  3  issue count minus 1; 0..7 gives 1..8 issues.
- sh_c  output  2  to shifter c.
- sh_s  output  3  to shifter s.
- sh_i  output  8  to shifter i.
- done  output  1  high while sh_* carry the final issue of a command.
- busy  output  1  FIFO non-empty or state is ISSUE.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- All outputs are registered.
- Reset, including mid-operation:
  - sh_c=00, sh_s=0, sh_i=0, done=0, busy=0.
  - FIFO flushed (count=0, pointers=0); state=IDLE.
  - Any in-progress repeats are abandoned.
  - cmd_ready is 1 from the first cycle after reset deasserts.
- Push: cmd_valid && cmd_ready at a posedge writes {op,amt,data,rep} at wr_ptr. cmd_valid while full is ignored (no write, no error).
- Pop: occurs at the edges described below. Push and pop in the same cycle when not full: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count is 0..DEPTH, PTR_W+1 bits.
- FSM states: IDLE, ISSUE.
- IDLE:
  - FIFO empty: sh_c<=00, done<=0.
  - FIFO non-empty: pop head; sh_c<=op, sh_s<=amt, sh_i<=data, rem<=rep, done<=(rep==0); go to ISSUE.
- ISSUE:
  - rem!=0: rem<=rem-1; sh_* unchanged; done<=(rem==1).
  - rem==0 and FIFO non-empty: pop next command and load it exactly as from IDLE (back-to-back, no bubble).
  - rem==0 and FIFO empty: sh_c<=00, done<=0; go to IDLE.
- Latency: a command pushed at edge T into an empty, idle sequencer drives sh_* from edge T+1. The shifter applies issue k at edge T+1+k.
- sh_s and sh_i hold their last values when sh_c returns to 00.
- op=00 with rep=N is a deliberate (N+1)-cycle hold.
- Amount 0 with op 01/10 is issued as given; the shifter treats it as a no-op.
- busy is registered: high in every cycle where state=ISSUE or count>0.
- No combinational path from cmd_* to sh_*.

Test Plan:
- Reset/idle: hold rst for 2 cycles, then release -> sh_c=00, done=0, busy=0, cmd_ready=1; with no pushes, outputs stay unchanged for 10 cycles.
- Single load: push {11,0,8'hA5,0} at T -> at T+1 sh_c=11, sh_i=A5, done=1; at T+2 sh_c=00, done=0, busy=0. Shifter o=A5.
- Repeat shift: after loading 8'h01, push {01,3'd1,x,3'd6} -> sh_c=01 for exactly 7 cycles, done high only on the 7th. Shifter o=8'h80.
- Back-to-back and full:
  - Push 4 commands on consecutive cycles while the first has rep=7 -> cmd_ready=0 after the 4th push; a 5th push with cmd_valid=1 is dropped.
  - Commands are issued in order with no 00 cycle between them; cmd_ready returns to 1 the cycle after the first pop.
- Simultaneous push/pop: keep one entry in the FIFO while the sequencer pops each cycle (rep=0) -> count stays 1; sh_c follows the pushed op sequence 01,10,11 one per cycle.
- Mid-operation reset: assert rst during repeat 3 of an rep=7 command with 2 entries queued -> next cycle sh_c=00, busy=0, done=0. After release, no queued command is issued.
